// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Summary  : MaxiCore32 instruction fetch sequencer with a DEPTH-entry buffer
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc_read_data,
    output logic        o_pc_inc,
    output logic        o_pc_write,
    output logic [31:0] o_pc_write_data,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr_data,
    output logic [31:0] o_instr_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    input  logic        i_halt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mem_req;
    logic               w_mem_req_nxt;
    logic [31:0]        r_mem_addr;
    logic [31:0]        w_mem_addr_nxt;

    logic [31:0]        r_buf_data [DEPTH];
    logic [31:0]        r_buf_pc   [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_redir;
    logic               w_push;
    logic               w_pop;
    logic               w_can_issue;

    // Redirects are ignored in IDLE, so all PC controls stay low during reset.
    assign w_redir     = i_redirect && (r_state != S_IDLE);
    assign w_push      = (r_state == S_WAIT) && i_mem_ack && !w_redir;
    assign w_pop       = (r_count != '0) && i_instr_ready;
    assign w_can_issue = !i_halt && (r_count < C_DEPTH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (!w_redir && w_can_issue) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = i_pc_read_data;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_ISSUE;
                end else if (w_redir) begin
                    w_state_nxt   = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The stale request must still complete before a new one issues.
                if (i_mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else if (w_redir) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_buf_data[r_tail] <= i_mem_rdata;
                r_buf_pc[r_tail]   <= r_mem_addr;
                r_tail             <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_pc_inc        = w_push;
    assign o_pc_write      = w_redir;
    assign o_pc_write_data = i_rst_n ? i_redirect_target : 32'h0;
    assign o_mem_req       = r_mem_req;
    assign o_mem_addr      = r_mem_addr;
    assign o_instr_valid   = (r_count != '0);
    assign o_instr_data    = r_buf_data[r_head];
    assign o_instr_pc      = r_buf_pc[r_head];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Summary  : Directed bench for fetch_unit with PC and memory models
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_TGT = 32'hCAFE0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        pc_inc, pc_write;
    logic [31:0] pc_write_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data, instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = C_TGT;
    logic        halt = 1'b0;

    int          ack_delay = 0;
    int          wcnt = 0;
    logic        pc_follow_rst = 1'b1;
    int          n_tests = 0;
    int          n_fail = 0;

    fetch_unit #(.DEPTH(2)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_pc_read_data    (pc),
        .o_pc_inc          (pc_inc),
        .o_pc_write        (pc_write),
        .o_pc_write_data   (pc_write_data),
        .o_mem_req         (mem_req),
        .o_mem_addr        (mem_addr),
        .i_mem_ack         (mem_ack),
        .i_mem_rdata       (mem_rdata),
        .o_instr_valid     (instr_valid),
        .i_instr_ready     (instr_ready),
        .o_instr_data      (instr_data),
        .o_instr_pc        (instr_pc),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .i_halt            (halt)
    );

    always #5 clk = ~clk;

    // Memory acks after ack_delay cycles of a held request.
    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end
    assign mem_ack   = mem_req && (wcnt >= ack_delay);
    assign mem_rdata = (mem_addr == 32'h0) ? 32'h11111111 :
                       (mem_addr == 32'h4) ? 32'h22222222 :
                       {16'hDEAD, mem_addr[15:0]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (pc_follow_rst) pc <= 32'h0;
        end else if (pc_write) begin
            pc <= pc_write_data;
        end else if (pc_inc) begin
            pc <= pc + 32'd4;
        end
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        inc;
        logic        valid;
        logic [31:0] data;
        logic [31:0] ipc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rdy, logic rq, logic [31:0] a,
                                logic inc, logic v, logic [31:0] d, logic [31:0] ip);
        vec_t t;
        t.rst = r; t.ready = rdy; t.req = rq; t.addr = a;
        t.inc = inc; t.valid = v; t.data = d; t.ipc = ip;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after release (DUT in IDLE).
    task automatic do_reset();
        redirect = 1'b0;
        halt     = 1'b0;
        rst_n    = 1'b0;
        next_cycle();
        next_cycle();
        rst_n    = 1'b1;
    endtask

    initial begin
        logic [131:0] got, exp;
        int           cnt_a, cnt_b;

        // Table 1: reset and first fetches with decode always ready
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 1, 32'h0, 1, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 1, 32'h11111111, 32'h0));
        vecs.push_back(mk(1, 1, 1, 32'h4, 1, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 1, 32'h22222222, 32'h4));
        // Table 2: backpressure fills the two entries, one pop frees a slot
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h0, 1, 0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 32'h11111111, 32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h4, 1, 1, 32'h11111111, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 32'h11111111, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 32'h11111111, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 1, 32'h11111111, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 32'h22222222, 32'h4));
        vecs.push_back(mk(1, 0, 1, 32'h8, 1, 1, 32'h22222222, 32'h4));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0, 1, 32'h22222222, 32'h4));

        foreach (vecs[i]) begin
            rst_n       = vecs[i].rst;
            instr_ready = vecs[i].ready;
            @(negedge clk);
            got = {mem_req,
                   (vecs[i].req || !vecs[i].rst) ? mem_addr : 32'h0,
                   pc_inc, pc_write, pc_write_data, instr_valid,
                   (vecs[i].valid || !vecs[i].rst) ? instr_data : 32'h0,
                   (vecs[i].valid || !vecs[i].rst) ? instr_pc   : 32'h0};
            exp = {vecs[i].req, vecs[i].addr, vecs[i].inc, 1'b0,
                   vecs[i].rst ? C_TGT : 32'h0, vecs[i].valid,
                   vecs[i].data, vecs[i].ipc};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec %0d: got %h, expected %h", i, got, exp);
            end
            next_cycle();
        end

        // Redirect while waiting on a slow memory
        ack_delay = 3; instr_ready = 1'b1;
        do_reset(); next_cycle(); next_cycle();
        redirect = 1'b1; redirect_target = 32'h100;
        @(negedge clk);
        check("s3 pc_write", {31'h0, pc_write}, 32'h1);
        check("s3 pc_write_data", pc_write_data, 32'h100);
        check("s3 pc_inc", {31'h0, pc_inc}, 32'h0);
        next_cycle();
        redirect = 1'b0;
        cnt_a = 0; cnt_b = 0;
        repeat (4) begin
            @(negedge clk);
            if (instr_valid) cnt_a++;
            if (pc_inc)      cnt_b++;
            next_cycle();
        end
        check("s3 late data valid", cnt_a, 0);
        check("s3 late data pc_inc", cnt_b, 0);
        @(negedge clk);
        check("s3 next req", {31'h0, mem_req}, 32'h1);
        check("s3 next addr", mem_addr, 32'h100);

        // Redirect in the ack cycle, with a pop in the same cycle
        ack_delay = 0; instr_ready = 1'b0;
        do_reset(); next_cycle(); next_cycle(); next_cycle();
        @(negedge clk);
        check("s4 count1 valid", {31'h0, instr_valid}, 32'h1);
        next_cycle();
        redirect = 1'b1; redirect_target = 32'h100; instr_ready = 1'b1;
        @(negedge clk);
        check("s4 pc_inc suppressed", {31'h0, pc_inc}, 32'h0);
        check("s4 pc_write", {31'h0, pc_write}, 32'h1);
        next_cycle();
        redirect = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        check("s4 flushed valid", {31'h0, instr_valid}, 32'h0);
        check("s4 idle req", {31'h0, mem_req}, 32'h0);
        next_cycle();
        @(negedge clk);
        check("s4 next addr", mem_addr, 32'h100);
        check("s4 next req", {31'h0, mem_req}, 32'h1);
        check("s4 still empty", {31'h0, instr_valid}, 32'h0);

        // Halt raised while a fetch is in flight
        ack_delay = 2; instr_ready = 1'b1; redirect_target = C_TGT;
        do_reset(); next_cycle(); next_cycle();
        halt = 1'b1;
        cnt_a = 0;
        repeat (3) begin
            @(negedge clk);
            if (pc_inc) cnt_a++;
            next_cycle();
        end
        check("s5 in-flight pc_inc", cnt_a, 1);
        @(negedge clk);
        check("s5 pushed valid", {31'h0, instr_valid}, 32'h1);
        check("s5 pushed data", instr_data, 32'h11111111);
        cnt_b = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_req) cnt_b++;
            next_cycle();
        end
        check("s5 no req while halted", cnt_b, 0);
        halt = 1'b0;
        @(negedge clk);
        check("s5 unhalt req latency", {31'h0, mem_req}, 32'h0);
        next_cycle();
        @(negedge clk);
        check("s5 resume req", {31'h0, mem_req}, 32'h1);
        check("s5 resume addr", mem_addr, 32'h4);

        // Asynchronous reset in WAIT with one buffered word
        ack_delay = 0; instr_ready = 1'b0;
        do_reset(); next_cycle(); next_cycle(); next_cycle();
        ack_delay = 3;
        next_cycle();
        @(negedge clk);
        check("s6 pre req", {31'h0, mem_req}, 32'h1);
        check("s6 pre valid", {31'h0, instr_valid}, 32'h1);
        #2;
        pc_follow_rst = 1'b0;
        rst_n = 1'b0;
        #1;
        check("s6 async req", {31'h0, mem_req}, 32'h0);
        check("s6 async valid", {31'h0, instr_valid}, 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle(); next_cycle();
        @(negedge clk);
        check("s6 restart req", {31'h0, mem_req}, 32'h1);
        check("s6 restart addr", mem_addr, 32'h4);
        pc_follow_rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
